nco_tone_sequencer: RTL
=======================

NCO_TONE_SEQUENCER -- requirements
Module: nco_tone_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: tone-table entries, power of two.
REQ-002 Parameter TICK_W, default 12: prescaler width; one duration tick every 2^TICK_W clk cycles.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 wr_valid  in  1  table byte write strobe.
REQ-006 wr_data  in  8  table byte.
REQ-007 wr_ready  out  1  write accepted this cycle; high only in IDLE.
REQ-008 clr  in  1  empty the table.
REQ-009 start  in  1  begin playback.
REQ-010 stop  in  1  abort playback.
REQ-011 loop  in  1  level; repeat the sequence while high.
REQ-012 freq_word  out  8  phase increment to the NCO accumulator.
REQ-013 tone_idx  out  $clog2(DEPTH)  entry currently playing.
REQ-014 busy  out  1  high in PLAY.
REQ-015 done  out  1  one-cycle pulse at natural end of sequence.

Function
REQ-016 States SHALL be exactly IDLE and PLAY.
REQ-017 In IDLE, a byte SHALL be accepted when wr_valid && !clr, stored at wr_ptr (0..2*DEPTH-1); wr_ptr then increments, wrapping to 0.
REQ-018 Even wr_ptr SHALL address entry[wr_ptr/2].freq; odd wr_ptr SHALL address entry[wr_ptr/2].dur.
REQ-019 Accepting a dur byte SHALL set length = max(length, wr_ptr/2+1); length saturates at DEPTH.
REQ-020 clr in IDLE SHALL zero wr_ptr and length next cycle; clr beats a simultaneous wr_valid (byte dropped); clr in PLAY SHALL be ignored.
REQ-021 wr_valid in PLAY SHALL be dropped with wr_ready=0.
REQ-022 start in IDLE with length>0 and stop=0 SHALL enter PLAY with tone_idx=0, clear the prescaler, and load the dur counter; freq_word = entry[0].freq from the next cycle (latency 1).
REQ-023 start with length==0, or start in PLAY, SHALL be ignored.
REQ-024 The prescaler SHALL count every PLAY cycle and tick when all ones; each tick decrements the dur counter.
REQ-025 dur value d SHALL last d ticks; d=0 SHALL mean 256 ticks.
REQ-026 On the tick that expires an entry: if tone_idx<length-1, advance to tone_idx+1 and load its dur; else if loop=1, wrap to 0; else return to IDLE and pulse done for one cycle.
REQ-027 stop SHALL force IDLE next cycle from any state, with no done pulse; stop beats a simultaneous start or expiry.
REQ-028 freq_word SHALL be 0 in IDLE; entry freq 0 is a legal rest.
REQ-029 The table SHALL be retained across playback and stop; only clr or rst empties it.

Reset
REQ-030 rst SHALL asynchronously force IDLE, wr_ptr=0, length=0, prescaler=0, dur counter=0, tone_idx=0, freq_word=0, busy=0, done=0, wr_ready=1 after release.
REQ-031 rst during PLAY SHALL abort immediately with no done pulse; table contents need not be cleared but are unreachable until rewritten.

Structure
REQ-032 Package nco_seq_pkg SHALL hold the state enum and the DEPTH/TICK_W defaults.
REQ-033 The prescaler SHALL be sub-module nco_seq_ticker (inputs clr, en; output tick); the table SHALL be flops inside the top.

Verification (TICK_W=2, DEPTH=8)
REQ-034 Write 10,3,20,1; start -> freq_word 10 for 12 cycles, 20 for 4 cycles, then 0, done pulse once, busy falls.
REQ-035 Same table, loop=1 -> freq_word sequence 10,20,10,20... continues until stop; stop -> freq_word 0 next cycle, no done.
REQ-036 Write entry dur=0 -> that tone lasts 1024 cycles.
REQ-037 Write 18 bytes -> wr_ptr wraps; entry 0 overwritten by bytes 17-18, length=8.
REQ-038 clr with wr_valid same cycle -> byte dropped, length 0; subsequent start ignored, busy stays 0.
REQ-039 rst asserted mid-PLAY -> all outputs at reset values on the same edge; start after release with empty table ignored.

Source files
------------

// File: rtl/nco_seq_pkg.sv
// Shared types and defaults for the NCO tone sequencer.
package nco_seq_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int TICK_W_DEF = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // A stored duration of 0 stands for the longest tone, 256 ticks.
    function automatic logic [8:0] dur_load(input logic [7:0] d);
        return (d == 8'd0) ? 9'd256 : {1'b0, d};
    endfunction

endpackage

// File: rtl/nco_seq_ticker.sv
// Free-running duration prescaler: one tick every 2^TICK_W enabled cycles.
module nco_seq_ticker #(
    parameter int TICK_W = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [TICK_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + TICK_W'(1);
    end

    assign tick = en && (&cnt);

endmodule

// File: rtl/nco_tone_sequencer.sv
// Plays a byte-programmed table of (freq, dur) entries as NCO phase increments.
// state   | meaning
// IDLE    | table writable, freq_word = 0, waiting for start
// PLAY    | stepping through entries, one dur tick per prescaler wrap
module nco_tone_sequencer
    import nco_seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     clr,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic [7:0]               freq_word,
    output logic [$clog2(DEPTH)-1:0] tone_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;

    state_t          state, state_nxt;
    logic [LW-1:0]   wr_ptr;
    logic [LW-1:0]   length;
    logic [8:0]      dur_cnt;
    logic [7:0]      freq_tab [DEPTH];
    logic [7:0]      dur_tab  [DEPTH];
    logic            play, tick, done_nxt;
    logic            accept_wr, start_ok, expire, last;
    logic [IW-1:0]   wr_ent, nxt_idx;
    logic [LW-1:0]   wr_ent_p1, idx_p1;

    assign play      = (state == ST_PLAY);
    assign accept_wr = !play && wr_valid && !clr;
    assign start_ok  = !play && start && !stop && (length != '0);
    assign expire    = play && tick && (dur_cnt == 9'd1);
    assign wr_ent    = wr_ptr[LW-1:1];
    assign wr_ent_p1 = {1'b0, wr_ent} + LW'(1);
    assign nxt_idx   = tone_idx + IW'(1);
    assign idx_p1    = {1'b0, tone_idx} + LW'(1);
    assign last      = (idx_p1 >= length);

    assign wr_ready  = !play;
    assign busy      = play;
    assign freq_word = play ? freq_tab[tone_idx] : 8'd0;

    nco_seq_ticker #(.TICK_W(TICK_W)) u_ticker (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .en   (play),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (expire && last && !loop) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Table has no reset; length=0 keeps stale entries unreachable.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            if (wr_ptr[0])
                dur_tab[wr_ent] <= wr_data;
            else
                freq_tab[wr_ent] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            length   <= '0;
            dur_cnt  <= '0;
            tone_idx <= '0;
            done     <= 1'b0;
        end else begin
            done <= done_nxt;
            if (!play && clr) begin
                wr_ptr <= '0;
                length <= '0;
            end else if (accept_wr) begin
                wr_ptr <= wr_ptr + LW'(1);
                if (wr_ptr[0] && (length < wr_ent_p1))
                    length <= wr_ent_p1;
            end

            if (start_ok) begin
                tone_idx <= '0;
                dur_cnt  <= dur_load(dur_tab[0]);
            end else if (play && stop) begin
                tone_idx <= '0;
                dur_cnt  <= '0;
            end else if (play && tick) begin
                if (dur_cnt == 9'd1) begin
                    if (!last) begin
                        tone_idx <= nxt_idx;
                        dur_cnt  <= dur_load(dur_tab[nxt_idx]);
                    end else if (loop) begin
                        tone_idx <= '0;
                        dur_cnt  <= dur_load(dur_tab[0]);
                    end else begin
                        tone_idx <= '0;
                        dur_cnt  <= '0;
                    end
                end else begin
                    dur_cnt <= dur_cnt - 9'd1;
                end
            end
        end
    end

endmodule
